// File: rtl/rv32_alu.sv
// rv32_alu -- single-cycle RV32I integer ALU for the execute stage.
//
// Ports:
//   clk     in   system clock (only used when the output register is built in)
//   rst     in   synchronous active-high reset (only used with the output register)
//   alu_op  in   [3:0] operation select (alu_op_t encoding, see localparams below)
//   in_a    in   [WIDTH-1:0] operand A (rs1 / PC)
//   in_b    in   [WIDTH-1:0] operand B (rs2 / immediate); shifts use in_b[4:0] only
//   result  out  [WIDTH-1:0] operation result
//   zero    out  1 when a valid op produces result == 0; never set for invalid ops
//
// Build option:
//   RV32_ALU_OUT_REG_EN  when defined, result/zero are registered (1-cycle latency,
//                        sync reset clears both to 0). Undefined: purely combinational.
//
// Only WIDTH = 32 is meaningful for RV32I.

module rv32_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned ShW = $clog2(WIDTH);

    // alu_op_t encoding
    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpSll  = 4'b0010;
    localparam logic [3:0] OpSlt  = 4'b0011;
    localparam logic [3:0] OpSltu = 4'b0100;
    localparam logic [3:0] OpXor  = 4'b0101;
    localparam logic [3:0] OpSrl  = 4'b0110;
    localparam logic [3:0] OpSra  = 4'b0111;
    localparam logic [3:0] OpOr   = 4'b1000;
    localparam logic [3:0] OpAnd  = 4'b1001;

    // ------------------------------------------------------------------
    // Shared adder/subtractor. SUB, SLT and SLTU all take the a - b path
    // so the compares reuse the subtractor instead of separate comparators.
    // ------------------------------------------------------------------
    logic             sub_sel;
    logic [WIDTH-1:0] b_operand;
    logic [WIDTH:0]   addsub_ext;
    logic [WIDTH-1:0] addsub;
    logic             lt_unsigned;
    logic             lt_signed;

    always_comb begin
        sub_sel = (alu_op == OpSub) || (alu_op == OpSlt) || (alu_op == OpSltu);
        b_operand = sub_sel ? ~in_b : in_b;
        addsub_ext = {1'b0, in_a} + {1'b0, b_operand} + {{WIDTH{1'b0}}, sub_sel};
        addsub = addsub_ext[WIDTH-1:0];
        // For a - b computed as a + ~b + 1, carry out is the inverted borrow.
        lt_unsigned = ~addsub_ext[WIDTH];
        // Differing signs: the negative operand is smaller, and the difference
        // may overflow, so only trust the difference sign when signs match.
        if (in_a[WIDTH-1] != in_b[WIDTH-1]) begin
            lt_signed = in_a[WIDTH-1];
        end else begin
            lt_signed = addsub[WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Shifter. Upper bits of in_b are ignored by construction.
    // ------------------------------------------------------------------
    logic [ShW-1:0]   shamt;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr_logic;
    logic [WIDTH-1:0] shr_arith;

    always_comb begin
        shamt     = in_b[ShW-1:0];
        shl       = in_a << shamt;
        shr_logic = in_a >> shamt;
        shr_arith = $signed(in_a) >>> shamt;
    end

    // ------------------------------------------------------------------
    // Result mux and zero flag.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] res_c;
    logic             valid_c;
    logic             zero_c;

    always_comb begin
        res_c   = '0;
        valid_c = 1'b1;
        case (alu_op)
            OpAdd:   res_c = addsub;
            OpSub:   res_c = addsub;
            OpSll:   res_c = shl;
            OpSlt:   res_c = {{(WIDTH-1){1'b0}}, lt_signed};
            OpSltu:  res_c = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OpXor:   res_c = in_a ^ in_b;
            OpSrl:   res_c = shr_logic;
            OpSra:   res_c = shr_arith;
            OpOr:    res_c = in_a | in_b;
            OpAnd:   res_c = in_a & in_b;
            default: begin
                res_c   = '0;
                valid_c = 1'b0;
            end
        endcase
        // Invalid ops drive 0 but must not look like "equal" to the branch unit.
        zero_c = valid_c && (res_c == '0);
    end

`ifdef RV32_ALU_OUT_REG_EN
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= res_c;
            zero_q   <= zero_c;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
`else
    // Clock and reset exist only for the registered build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign result = res_c;
    assign zero   = zero_c;
`endif

endmodule

// File: tb/tb_rv32_alu.sv
// Self-checking bench for rv32_alu: directed vector table, hand-written
// reset/latency sequences, and a random regression against a reference model.
// Works for both the combinational and RV32_ALU_OUT_REG_EN builds.

module tb_rv32_alu;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                           XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  alu_op = 4'hF;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] result;
    logic        zero;

    int total = 0;
    int bad   = 0;

    rv32_alu #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .alu_op (alu_op),
        .in_a   (in_a),
        .in_b   (in_b),
        .result (result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic z);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.r = r; v.z = z;
        vecs.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] got_r, input logic got_z,
                         input logic [31:0] exp_r, input logic exp_z);
        total++;
        if (got_r !== exp_r || got_z !== exp_z) begin
            bad++;
            $display("FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                     tag, got_r, got_z, exp_r, exp_z);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    // Valid for both builds: registered outputs capture at the rising edge,
    // combinational outputs are already stable.
    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_op = op;
        in_a   = a;
        in_b   = b;
        @(posedge clk);
        #1;
    endtask

    // Reference model: returns {zero, result}.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        v = 1'b1;
        case (op)
            ADD:  r = a + b;
            SUB:  r = a - b;
            SLL:  r = a << b[4:0];
            SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU: r = (a < b) ? 32'd1 : 32'd0;
            XOR:  r = a ^ b;
            SRL:  r = a >> b[4:0];
            SRA:  r = $signed(a) >>> b[4:0];
            OR:   r = a | b;
            AND:  r = a & b;
            default: begin
                r = 32'd0;
                v = 1'b0;
            end
        endcase
        return {v && (r == 32'd0), r};
    endfunction

    initial begin
        logic [32:0] exp;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Directed vectors with hand-computed expectations.
        add_vec(ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        add_vec(ADD,  32'd5,         32'd7,         32'd12,        1'b0);
        add_vec(SUB,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1);
        add_vec(SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        add_vec(SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
        add_vec(SLL,  32'h8000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0);
        add_vec(SRL,  32'h8000_0001, 32'h0000_0021, 32'h4000_0000, 1'b0);
        add_vec(SRA,  32'h8000_0001, 32'h0000_0021, 32'hC000_0000, 1'b0);
        add_vec(SLL,  32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 1'b0);
        add_vec(SRL,  32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 1'b0);
        add_vec(SRA,  32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 1'b0);
        add_vec(SRA,  32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        add_vec(SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0);
        add_vec(SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
        add_vec(SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        add_vec(SLT,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1);
        add_vec(SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        add_vec(SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1);
        add_vec(SLTU, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b0);
        add_vec(AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
        add_vec(OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
        add_vec(XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
        add_vec(XOR,  32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0000_0000, 1'b1);
        add_vec(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b0);
        add_vec(4'hA, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add_vec(4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

        // Reset state: invalid op is held during reset, so both builds show 0/0.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", result, zero, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_op%0h", i, vecs[i].op), result, zero, vecs[i].r, vecs[i].z);
        end

`ifdef RV32_ALU_OUT_REG_EN
        // One-cycle latency: new inputs are not visible before the next edge.
        apply(ADD, 32'd5, 32'd7);
        @(negedge clk);
        alu_op = SUB;
        in_a   = 32'd9;
        in_b   = 32'd9;
        #1;
        check("latency_hold", result, zero, 32'd12, 1'b0);
        @(posedge clk);
        #1;
        check("latency_update", result, zero, 32'd0, 1'b1);

        // Reset clears both outputs and wins over a pending valid op.
        apply(ADD, 32'd5, 32'd7);
        @(negedge clk);
        rst    = 1'b1;
        alu_op = ADD;
        in_a   = 32'd100;
        in_b   = 32'd1;
        @(posedge clk);
        #1;
        check("reset_clears", result, zero, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset", result, zero, 32'd101, 1'b0);

        // Invalid op captured as 0/0 even after a zero-producing op.
        apply(SUB, 32'd3, 32'd3);
        check("reg_zero_op", result, zero, 32'h0, 1'b1);
        apply(4'hB, 32'd3, 32'd3);
        check("reg_invalid", result, zero, 32'h0, 1'b0);
`else
        // Reset has no effect in the combinational build.
        @(negedge clk);
        rst    = 1'b1;
        alu_op = ADD;
        in_a   = 32'd5;
        in_b   = 32'd7;
        #1;
        check("comb_ignores_rst", result, zero, 32'd12, 1'b0);
        @(posedge clk);
        #1;
        check("comb_ignores_clk", result, zero, 32'd12, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // Output follows inputs within the same cycle.
        alu_op = 4'hB;
        in_a   = 32'd3;
        in_b   = 32'd3;
        #1;
        check("comb_invalid", result, zero, 32'h0, 1'b0);
`endif

        // Random regression: mixed ops (including invalid encodings).
        for (int n = 0; n < 1500; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            apply(op, a, b);
            exp = ref_alu(op, a, b);
            check($sformatf("rand_mix%0d_op%0h_a%h_b%h", n, op, a, b), result, zero,
                  exp[31:0], exp[32]);
        end

        // Random regression: SUB only, with frequent equal operands and edges.
        for (int n = 0; n < 3500; n++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = a;
                1:       b = 32'h1;
                2:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            apply(SUB, a, b);
            exp = ref_alu(SUB, a, b);
            check($sformatf("rand_sub%0d_a%h_b%h", n, a, b), result, zero, exp[31:0], exp[32]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_alu.md
Name: rv32_alu

Overview:
- Single-cycle RV32I integer ALU in the riscv_32i datapath execute stage.
- Takes a 4-bit ALU opcode of type alu_op_t from riscv_32i_control_pkg and two 32-bit operands.
- Produces a 32-bit result and a zero flag; the branch unit uses the zero flag.
- Default build is purely combinational; clk/rst are used only when the optional output register is compiled in.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is supported for RV32I.
- Shift amount is in_b[$clog2(WIDTH)-1:0].

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- alu_op  input  4  operation select (alu_op_t).
- in_a  input  WIDTH  operand A (rs1 / PC).
- in_b  input  WIDTH  operand B (rs2 / immediate).
- result  output  WIDTH  operation result.
- zero  output  1  1 when a valid op yields result == 0.

Behaviour:
- Opcode encoding (alu_op_t) and result:
  - 4'b0000 ADD: a+b modulo 2^32, carry discarded.
  - 4'b0001 SUB: a-b modulo 2^32, borrow discarded.
  - 4'b0010 SLL: a << b[4:0].
  - 4'b0011 SLT: {31'b0, signed(a) < signed(b)}.
  - 4'b0100 SLTU: {31'b0, unsigned(a) < unsigned(b)}.
  - 4'b0101 XOR: a ^ b.
  - 4'b0110 SRL: a >> b[4:0], zero fill.
  - 4'b0111 SRA: a >>> b[4:0], sign fill.
  - 4'b1000 OR: a | b.
  - 4'b1001 AND: a & b.
- Invalid encodings 4'b1010 to 4'b1111: result = 0 and zero = 0.
  - zero is deliberately NOT asserted for invalid ops, even though result is 0.
- zero = (result == 0) for valid ops only.
- Shifts use only in_b[4:0]; in_b[31:5] are ignored. Shift by 0 returns a unchanged.
- Signed comparison must be correct across the sign boundary, e.g. 0x80000000 < 0x7FFFFFFF signed.
- Overflow does not trap or flag; it wraps silently.
- Default build (no macro):
  - result and zero are combinational functions of alu_op, in_a and in_b; settled within the same cycle.
  - clk and rst do not affect outputs.
  - No latches; every op path fully assigns result and zero.
- X-free: any fully known input produces fully known outputs.

Optional Feature:
- Macro: RV32_ALU_OUT_REG_EN.
- Defined:
  - result and zero are registered on posedge clk; latency is 1 cycle.
  - Sync rst=1 at a posedge sets result = 0 and zero = 0. Reset has priority over a new operation.
  - First valid output appears the cycle after rst deasserts.
  - The invalid-op rule is unchanged (registers capture 0/0).
- Undefined: behaves as the combinational default above.

Test Plan:
- ADD wrap: a=0xFFFFFFFF, b=0x00000001 -> result 0x00000000, zero 1.
- ADD plain: a=5, b=7 -> result 12, zero 0.
- SUB corner cases:
  - a=b=0x12345678 -> 0, zero 1.
  - a=0, b=1 -> 0xFFFFFFFF, zero 0.
  - a=0x80000000, b=1 -> 0x7FFFFFFF.
- Shifts with a=0x80000001, b=0x00000021 (amount 1):
  - SLL -> 0x00000002.
  - SRL -> 0x40000000.
  - SRA -> 0xC0000000.
  - Same ops with b=0 -> a unchanged.
- Compares with a=0xFFFFFFFF, b=1:
  - SLT -> 1.
  - SLTU -> 0.
  - Equal operands with SLT -> result 0, zero 1.
- Logic ops with a=0xF0F0F0F0, b=0x0FF00FF0:
  - AND -> 0x00F000F0.
  - OR -> 0xFFF0FFF0.
  - XOR -> 0xFF00FF00.
  - XOR with a==b -> 0, zero 1.
- Invalid op: alu_op=4'b1111, random a/b -> result 0, zero 0.
  - Under RV32_ALU_OUT_REG_EN, also check a 1-cycle delay and that rst clears both outputs to 0.
- Random regression: at least 1500 mixed-op and 3500 SUB-only transactions, checked against a reference model.
